// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if
//   Bundles the pipeline-side signals of the hazard/forwarding unit.
//   master : pipeline control (drives register-stage fields, reads controls)
//   slave  : hazard_forward_unit
//   Inputs to the unit : ex_mem_*, mem_wb_*, id_ex_*, if_id_*, mc_issue, mc_rd, flush
//   Outputs of the unit: fwd_sel, stall, id_ex_bubble, mc_busy, mc_done, mc_done_rd
interface hazard_forward_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);
    logic                      ex_mem_regwrite;
    logic [REG_AW-1:0]         ex_mem_rd;
    logic                      mem_wb_regwrite;
    logic [REG_AW-1:0]         mem_wb_rd;
    logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
    logic                      id_ex_memread;
    logic [REG_AW-1:0]         id_ex_rd;
    logic [NUM_SRC*REG_AW-1:0] if_id_rs;
    logic [NUM_SRC-1:0]        if_id_rs_used;
    logic                      if_id_is_mc;
    logic                      mc_issue;
    logic [REG_AW-1:0]         mc_rd;
    logic                      flush;

    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall;
    logic                      id_ex_bubble;
    logic                      mc_busy;
    logic                      mc_done;
    logic [REG_AW-1:0]         mc_done_rd;

    modport master (
        output ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd,
               id_ex_rs, id_ex_memread, id_ex_rd,
               if_id_rs, if_id_rs_used, if_id_is_mc,
               mc_issue, mc_rd, flush,
        input  fwd_sel, stall, id_ex_bubble, mc_busy, mc_done, mc_done_rd
    );

    modport slave (
        input  ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd,
               id_ex_rs, id_ex_memread, id_ex_rd,
               if_id_rs, if_id_rs_used, if_id_is_mc,
               mc_issue, mc_rd, flush,
        output fwd_sel, stall, id_ex_bubble, mc_busy, mc_done, mc_done_rd
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   EX-stage operand forwarding, load-use detection and a single-entry
//   scoreboard for a fixed-latency multi-cycle unit (issue at T -> done at
//   T+MC_LAT). Produces the IF/ID hold and ID/EX bubble controls.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     bus        hazard_forward_unit_if.slave (pipeline fields and controls)
//     stall_cnt  32-bit saturating count of stall cycles (HFU_STALL_CNT_EN only)
//   Build option: define HFU_STALL_CNT_EN to add the stall_cnt output.
//
//   state | meaning
//   IDLE  | multi-cycle unit free, no pending destination
//   BUSY  | op in flight; cnt counts down to 0, cnt==0 is the result cycle
module hazard_forward_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MC_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  bus
`ifdef HFU_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] pend_rd;
    logic              mc_busy_q;
    logic              mc_done_q;

    logic [NUM_SRC*2-1:0] fwd_c;
    logic                 hazard;
    logic                 mc_active;
    logic                 lu_hit;
    logic                 raw_hit;

    // Forwarding: youngest producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        logic [REG_AW-1:0] rs;
        fwd_c = '0;
        rs    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs = bus.id_ex_rs[i*REG_AW +: REG_AW];
            if (bus.ex_mem_regwrite && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == rs))
                fwd_c[i*2 +: 2] = 2'b10;
            else if (bus.mem_wb_regwrite && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == rs))
                fwd_c[i*2 +: 2] = 2'b01;
            else
                fwd_c[i*2 +: 2] = 2'b00;
        end
    end

    // The result cycle (cnt==0) is not treated as occupied: the consumer picks
    // the value up through MEM/WB forwarding and a new op may issue.
    assign mc_active = (state == BUSY) && (cnt != '0);

    always_comb begin
        logic [REG_AW-1:0] rs;
        lu_hit  = 1'b0;
        raw_hit = 1'b0;
        rs      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs = bus.if_id_rs[i*REG_AW +: REG_AW];
            if (bus.if_id_rs_used[i]) begin
                if (rs == bus.id_ex_rd) lu_hit  = 1'b1;
                if (rs == pend_rd)      raw_hit = 1'b1;
            end
        end
    end

    assign hazard = (bus.id_ex_memread && (bus.id_ex_rd != '0) && lu_hit)
                  || (mc_active && (pend_rd != '0) && raw_hit)
                  || (mc_active && bus.if_id_is_mc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_rd   <= '0;
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mc_issue) begin
                        state     <= BUSY;
                        cnt       <= CW'(MC_LAT - 1);
                        pend_rd   <= bus.mc_rd;
                        mc_busy_q <= 1'b1;
                        mc_done_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        // Issues here are blocked upstream by the structural stall.
                        cnt       <= cnt - CW'(1);
                        mc_done_q <= (cnt == CW'(1));
                    end else if (bus.mc_issue) begin
                        cnt       <= CW'(MC_LAT - 1);
                        pend_rd   <= bus.mc_rd;
                        mc_busy_q <= 1'b1;
                        mc_done_q <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        mc_busy_q <= 1'b0;
                        mc_done_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mc_busy_q <= 1'b0;
                    mc_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fwd_sel      = fwd_c;
    assign bus.stall        = hazard && !bus.flush;
    assign bus.id_ex_bubble = hazard || bus.flush;
    assign bus.mc_busy      = mc_busy_q;
    assign bus.mc_done      = mc_done_q;
    assign bus.mc_done_rd   = pend_rd;

`ifdef HFU_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
//   Drives one stimulus cycle at a time just after posedge, pushes the
//   expected outputs for that cycle, and compares them on the following negedge.
module tb_hazard_forward_unit;

    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;
    localparam int MC_LAT  = 4;

    logic clk;
    logic rst;
`ifdef HFU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_forward_unit_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) bus ();

    hazard_forward_unit #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MC_LAT(MC_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef HFU_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] fwd;
        logic       stall;
        logic       bub;
        logic       busy;
        logic       done;
        int         drd;   // -1: not checked
        int         sc;    // -1: not checked
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void sb_push(string tag, logic [3:0] fwd, logic st, logic bb,
                                    logic busy, logic done, int drd, int sc);
        sb.push_back('{tag, fwd, st, bb, busy, done, drd, sc});
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.tag, "/fwd"},   32'(bus.fwd_sel),      32'(e.fwd));
            check_val({e.tag, "/stall"}, 32'(bus.stall),        32'(e.stall));
            check_val({e.tag, "/bub"},   32'(bus.id_ex_bubble), 32'(e.bub));
            check_val({e.tag, "/busy"},  32'(bus.mc_busy),      32'(e.busy));
            check_val({e.tag, "/done"},  32'(bus.mc_done),      32'(e.done));
            if (e.drd >= 0)
                check_val({e.tag, "/done_rd"}, 32'(bus.mc_done_rd), 32'(e.drd));
`ifdef HFU_STALL_CNT_EN
            if (e.sc >= 0)
                check_val({e.tag, "/stall_cnt"}, stall_cnt, 32'(e.sc));
`endif
        end
    end

    task automatic clear_in();
        bus.ex_mem_regwrite = 1'b0;
        bus.ex_mem_rd       = '0;
        bus.mem_wb_regwrite = 1'b0;
        bus.mem_wb_rd       = '0;
        bus.id_ex_rs        = '0;
        bus.id_ex_memread   = 1'b0;
        bus.id_ex_rd        = '0;
        bus.if_id_rs        = '0;
        bus.if_id_rs_used   = '0;
        bus.if_id_is_mc     = 1'b0;
        bus.mc_issue        = 1'b0;
        bus.mc_rd           = '0;
        bus.flush           = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    function automatic logic [1:0] fwd_ref(logic exw, logic [4:0] exrd, logic mww,
                                           logic [4:0] mwrd, logic [4:0] rs);
        if (exw && exrd != 5'd0 && exrd == rs) return 2'b10;
        if (mww && mwrd != 5'd0 && mwrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rs0, rs1, idrd;
        logic [1:0] used;
        logic       lu;
        logic [3:0] fexp;

        rst = 1'b1;
        clear_in();
        tick();
        sb_push("reset", 4'b0000, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // forwarding
        tick();
        bus.ex_mem_regwrite = 1; bus.ex_mem_rd = 5; bus.mem_wb_regwrite = 1; bus.mem_wb_rd = 5;
        bus.id_ex_rs = {5'd0, 5'd5};
        sb_push("fwd_exmem", 4'b0010, 0, 0, 0, 0, -1, -1);
        tick();
        bus.ex_mem_regwrite = 0; bus.ex_mem_rd = 5; bus.mem_wb_regwrite = 1; bus.mem_wb_rd = 5;
        bus.id_ex_rs = {5'd0, 5'd5};
        sb_push("fwd_memwb", 4'b0001, 0, 0, 0, 0, -1, -1);
        tick();
        bus.ex_mem_regwrite = 1; bus.ex_mem_rd = 3; bus.mem_wb_regwrite = 1; bus.mem_wb_rd = 4;
        bus.id_ex_rs = {5'd3, 5'd4};
        sb_push("fwd_split", 4'b1001, 0, 0, 0, 0, -1, -1);
        tick();
        bus.ex_mem_regwrite = 1; bus.mem_wb_regwrite = 1;
        sb_push("fwd_r0", 4'b0000, 0, 0, 0, 0, -1, -1);

        // load-use
        tick();
        bus.id_ex_memread = 1; bus.id_ex_rd = 7; bus.if_id_rs = {5'd7, 5'd2}; bus.if_id_rs_used = 2'b11;
        sb_push("lu_hit", 4'b0000, 1, 1, 0, 0, -1, -1);
        tick();
        bus.id_ex_memread = 1; bus.id_ex_rd = 7; bus.if_id_rs = {5'd7, 5'd2}; bus.if_id_rs_used = 2'b01;
        sb_push("lu_unused", 4'b0000, 0, 0, 0, 0, -1, -1);
        tick();
        bus.id_ex_memread = 1; bus.id_ex_rd = 0; bus.if_id_rs_used = 2'b11;
        sb_push("lu_r0", 4'b0000, 0, 0, 0, 0, -1, -1);

        // multi-cycle RAW
        tick();
        bus.mc_issue = 1; bus.mc_rd = 9; bus.if_id_rs = 10'd9; bus.if_id_rs_used = 2'b01;
        sb_push("mc_issue", 4'b0000, 0, 0, 0, 0, -1, -1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.if_id_rs = 10'd9; bus.if_id_rs_used = 2'b01;
            sb_push("mc_raw", 4'b0000, 1, 1, 1, 0, -1, -1);
        end
        tick();
        bus.if_id_rs = 10'd9; bus.if_id_rs_used = 2'b01;
        sb_push("mc_done", 4'b0000, 0, 0, 1, 1, 9, -1);
        tick();
        sb_push("mc_idle", 4'b0000, 0, 0, 0, 0, -1, -1);

        // back-to-back with structural stall
        tick();
        bus.mc_issue = 1; bus.mc_rd = 10;
        sb_push("b2b_issue", 4'b0000, 0, 0, 0, 0, -1, -1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.if_id_is_mc = 1;
            sb_push("b2b_struct", 4'b0000, 1, 1, 1, 0, -1, -1);
        end
        tick();
        bus.if_id_is_mc = 1; bus.mc_issue = 1; bus.mc_rd = 11;
        sb_push("b2b_done1", 4'b0000, 0, 0, 1, 1, 10, -1);
        for (int c = 5; c <= 7; c++) begin
            tick();
            bus.if_id_rs = {5'd11, 5'd0}; bus.if_id_rs_used = 2'b10;
            sb_push("b2b_raw2", 4'b0000, 1, 1, 1, 0, -1, -1);
        end
        tick();
        bus.if_id_rs = {5'd11, 5'd0}; bus.if_id_rs_used = 2'b10;
        sb_push("b2b_done2", 4'b0000, 0, 0, 1, 1, 11, -1);
        tick();
        sb_push("b2b_idle", 4'b0000, 0, 0, 0, 0, -1, -1);

        // flush during RAW
        tick();
        bus.mc_issue = 1; bus.mc_rd = 12;
        sb_push("fl_issue", 4'b0000, 0, 0, 0, 0, -1, -1);
        tick();
        bus.if_id_rs = 10'd12; bus.if_id_rs_used = 2'b01; bus.flush = 1;
        sb_push("fl_flush1", 4'b0000, 0, 1, 1, 0, -1, -1);
        tick();
        bus.if_id_rs = 10'd12; bus.if_id_rs_used = 2'b01;
        sb_push("fl_raw", 4'b0000, 1, 1, 1, 0, -1, -1);
        tick();
        bus.if_id_rs = 10'd12; bus.if_id_rs_used = 2'b01; bus.flush = 1;
        sb_push("fl_flush2", 4'b0000, 0, 1, 1, 0, -1, -1);
        tick();
        sb_push("fl_done", 4'b0000, 0, 0, 1, 1, 12, -1);
        tick();
        bus.flush = 1;
        sb_push("fl_idle", 4'b0000, 0, 1, 0, 0, -1, -1);

        // destination r0: occupied but no RAW
        tick();
        bus.mc_issue = 1; bus.mc_rd = 0;
        sb_push("r0_issue", 4'b0000, 0, 0, 0, 0, -1, -1);
        tick();
        bus.if_id_rs = 10'd0; bus.if_id_rs_used = 2'b01;
        sb_push("r0_noraw", 4'b0000, 0, 0, 1, 0, -1, -1);
        tick();
        bus.if_id_is_mc = 1;
        sb_push("r0_struct", 4'b0000, 1, 1, 1, 0, -1, -1);
        tick();
        sb_push("r0_busy", 4'b0000, 0, 0, 1, 0, -1, -1);
        tick();
        sb_push("r0_done", 4'b0000, 0, 0, 1, 1, 0, -1);
        tick();
        sb_push("r0_idle", 4'b0000, 0, 0, 0, 0, -1, -1);

        // reset mid-operation
        tick();
        bus.mc_issue = 1; bus.mc_rd = 13;
        sb_push("rst_issue", 4'b0000, 0, 0, 0, 0, -1, -1);
        tick();
        sb_push("rst_busy", 4'b0000, 0, 0, 1, 0, -1, -1);
        tick();
        rst = 1'b1;
        sb_push("rst_mid", 4'b0000, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            tick();
            sb_push("rst_nodone", 4'b0000, 0, 0, 0, 0, -1, 0);
        end

        // stall counting, then reset clears it
        tick();
        bus.mc_issue = 1; bus.mc_rd = 14;
        sb_push("sc_issue", 4'b0000, 0, 0, 0, 0, -1, 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.if_id_rs = {5'd14, 5'd0}; bus.if_id_rs_used = 2'b10;
            sb_push("sc_raw", 4'b0000, 1, 1, 1, 0, -1, c - 1);
        end
        tick();
        sb_push("sc_done", 4'b0000, 0, 0, 1, 1, 14, 3);
        tick();
        rst = 1'b1;
        sb_push("sc_rst", 4'b0000, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // random forwarding / load-use with the unit idle
        for (int n = 0; n < 40; n++) begin
            tick();
            bus.ex_mem_regwrite = 1'($urandom_range(0, 1));
            bus.ex_mem_rd       = 5'($urandom_range(0, 3));
            bus.mem_wb_regwrite = 1'($urandom_range(0, 1));
            bus.mem_wb_rd       = 5'($urandom_range(0, 3));
            rs0 = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            bus.id_ex_rs = {rs1, rs0};
            bus.id_ex_memread = 1'($urandom_range(0, 1));
            idrd = 5'($urandom_range(0, 3));
            bus.id_ex_rd = idrd;
            used = 2'($urandom_range(0, 3));
            bus.if_id_rs_used = used;
            bus.if_id_rs = {rs0, rs1};
            bus.if_id_is_mc = 1'($urandom_range(0, 1));
            bus.flush = 1'($urandom_range(0, 1));
            fexp = {fwd_ref(bus.ex_mem_regwrite, bus.ex_mem_rd, bus.mem_wb_regwrite, bus.mem_wb_rd, rs1),
                    fwd_ref(bus.ex_mem_regwrite, bus.ex_mem_rd, bus.mem_wb_regwrite, bus.mem_wb_rd, rs0)};
            lu = bus.id_ex_memread && (idrd != 5'd0)
                 && ((used[0] && rs1 == idrd) || (used[1] && rs0 == idrd));
            sb_push("rand", fexp, lu && !bus.flush, lu || bus.flush, 0, 0, -1, -1);
        end

        tick();
        @(negedge clk);
        #1;
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised successor to the two-operand EX-stage forwarding unit. Generates forwarding selects for NUM_SRC source operands and detects load-use hazards. Adds a scoreboard for a single multi-cycle execution unit (divider class, fixed latency MC_LAT). Drives the pipeline stall/bubble controls between the IF/ID and ID/EX registers.

Parameters:
NUM_SRC, 2, number of source-register operands per instruction (1..3)
REG_AW, 5, register address width
MC_LAT, 4, multi-cycle unit latency in cycles from issue to result (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_mem_regwrite  in  1  EX/MEM writes register file
ex_mem_rd  in  REG_AW  EX/MEM destination
mem_wb_regwrite  in  1  MEM/WB writes register file
mem_wb_rd  in  REG_AW  MEM/WB destination
id_ex_rs  in  NUM_SRC*REG_AW  ID/EX sources, slot i at [i*REG_AW +: REG_AW]
id_ex_memread  in  1  ID/EX instruction is a load
id_ex_rd  in  REG_AW  ID/EX destination
if_id_rs  in  NUM_SRC*REG_AW  IF/ID sources, same packing
if_id_rs_used  in  NUM_SRC  per-slot "operand actually read"
if_id_is_mc  in  1  IF/ID instruction targets the multi-cycle unit
mc_issue  in  1  ID/EX multi-cycle op enters the unit this cycle
mc_rd  in  REG_AW  destination of issuing multi-cycle op
flush  in  1  branch/jump squash of IF/ID
fwd_sel  out  NUM_SRC*2  per-slot select: 10 EX/MEM, 01 MEM/WB, 00 register file
stall  out  1  hold PC and IF/ID
id_ex_bubble  out  1  insert NOP into ID/EX
mc_busy  out  1  multi-cycle unit occupied
mc_done  out  1  result valid this cycle
mc_done_rd  out  REG_AW  destination of completing op

Behaviour:
- Clock clk; reset rst is asynchronous, active-high. Registered outputs and state reset to 0 (state IDLE, cnt 0, pend_rd 0). mc_busy, mc_done, mc_done_rd = 0 during and after reset until an issue.
- Forwarding (combinational, per slot i): EX/MEM match (regwrite, rd!=0, rd==rs[i]) -> 10. Else MEM/WB match -> 01. Else 00. EX/MEM has priority.
- Load-use: id_ex_memread && id_ex_rd!=0 && any slot with if_id_rs_used[i] && if_id_rs[i]==id_ex_rd -> hazard.
- Scoreboard FSM IDLE/BUSY, counter width clog2(MC_LAT).
- IDLE + mc_issue: pend_rd<=mc_rd, cnt<=MC_LAT-1, go BUSY.
- BUSY: cnt decrements each cycle. mc_done = BUSY && cnt==0, with mc_done_rd = pend_rd.
- In the mc_done cycle: next state IDLE, or reload BUSY if mc_issue is asserted (back-to-back accepted).
- Issue in cycle T gives mc_done in cycle T+MC_LAT.
- mc_busy = state==BUSY.
- mc_issue in BUSY with cnt!=0 is ignored. The stall rules below prevent it.
- RAW on pending: BUSY && cnt!=0 && pend_rd!=0 && a used slot matches pend_rd -> hazard. The mc_done cycle does not stall; the consumer gets the result via MEM/WB forwarding.
- Structural: if_id_is_mc && BUSY && cnt!=0 -> hazard.
- mc_rd==0: unit is still occupied; no RAW hazard is raised.
- stall = hazard && !flush.
- id_ex_bubble = hazard || flush.
- flush does not cancel an op already issued; the scoreboard runs to completion.
- Reset mid-operation: pending op abandoned, mc_done never pulses for it.

Optional Feature:
HFU_STALL_CNT_EN
- Defined: adds output stall_cnt (32 bits), reset 0. Increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ex_mem_rd=5 and mem_wb_rd=5, both regwrite, id_ex_rs slot0=5, slot1=0 -> fwd_sel slot0=10, slot1=00. Repeat with ex_mem_regwrite=0 -> slot0=01.
- id_ex_memread=1, id_ex_rd=7, if_id_rs slot1=7 used -> stall=1, bubble=1. Same with if_id_rs_used[1]=0 -> stall=0.
- MC_LAT=4: mc_issue, mc_rd=9 at cycle 0; if_id_rs=9 used -> stall 1..3, mc_done=1 with mc_done_rd=9 at cycle 4, stall=0 at cycle 4.
- Back-to-back: second mc_issue in cycle 4 -> busy continuous, next mc_done at cycle 8. if_id_is_mc during 1..3 -> stall.
- flush=1 during a RAW hazard -> stall=0, bubble=1; scoreboard still completes at T+MC_LAT.
- rst asserted at cycle 2 of a pending op -> mc_busy=0 immediately, no mc_done afterward. With HFU_STALL_CNT_EN: three stall cycles -> stall_cnt=3, then 0 after reset.
